// File: rtl/spi_frame_sampler.sv
// ============================================================================
// Module   : spi_frame_sampler
// Brief    : Oversampling SPI receiver. Synchronizes cs_n/sclk/data_in into
//            sys_clk, frames words and flags truncated or aborted frames.
//            Optional macro SPI_SAMPLER_TIMEOUT_EN enables the idle-frame abort.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_frame_sampler #(
   parameter int DATA_WIDTH     = 8,
   parameter int FALL_EDGE      = 0,
   parameter int MSB_FIRST      = 1,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                                sys_clk,
   input  logic                                rst,
   input  logic                                en,
   input  logic                                cs_n,
   input  logic                                sclk,
   input  logic                                data_in,
   output logic [DATA_WIDTH-1:0]               data_out,
   output logic                                data_valid,
   output logic                                frame_active,
   output logic                                frame_err,
   output logic [$clog2(DATA_WIDTH+1)-1:0]     bit_cnt
);

   localparam int C_CNT_W = $clog2(DATA_WIDTH + 1);

   generate
      if (DATA_WIDTH < 2 || DATA_WIDTH > 32 || TIMEOUT_CYCLES < 1) begin : g_param_check
         $error("spi_frame_sampler: illegal parameter value");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_STARTUP = 2'd0,
      ST_IDLE    = 2'd1,
      ST_ACTIVE  = 2'd2
   } state_t;

   state_t                r_state;
   logic [1:0]            r_cs_sync;
   logic [1:0]            r_sclk_sync;
   logic [1:0]            r_din_sync;
   logic                  r_cs_prev;
   logic                  r_sclk_prev;
   logic [1:0]            r_stab_cnt;
   logic                  r_ev_cs_fall;
   logic                  r_ev_cs_rise;
   logic                  r_ev_sample;
   logic                  r_ev_bit;
   logic [DATA_WIDTH-1:0] r_shift;

   logic                  w_stable;
   logic                  w_cs_fall;
   logic                  w_cs_rise;
   logic                  w_sclk_edge;
   logic                  w_word_done;
   logic                  w_timeout;
   logic                  w_frame_end;
   logic [DATA_WIDTH-1:0] w_shift_next;

   assign w_stable    = (r_stab_cnt == 2'd3);
   assign w_cs_fall   = r_cs_prev & ~r_cs_sync[1];
   assign w_cs_rise   = ~r_cs_prev & r_cs_sync[1];
   assign w_sclk_edge = (FALL_EDGE != 0) ? (r_sclk_prev & ~r_sclk_sync[1])
                                         : (~r_sclk_prev & r_sclk_sync[1]);

   assign w_shift_next = (MSB_FIRST != 0) ? {r_shift[DATA_WIDTH-2:0], r_ev_bit}
                                          : {r_ev_bit, r_shift[DATA_WIDTH-1:1]};

   assign w_word_done = (bit_cnt == C_CNT_W'(DATA_WIDTH));

   // Data bit is registered alongside the sclk edge it belongs to, so both
   // reach the capture logic from the same synchronizer stage.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         r_cs_sync    <= '0;
         r_sclk_sync  <= '0;
         r_din_sync   <= '0;
         r_cs_prev    <= 1'b0;
         r_sclk_prev  <= 1'b0;
         r_stab_cnt   <= '0;
         r_ev_cs_fall <= 1'b0;
         r_ev_cs_rise <= 1'b0;
         r_ev_sample  <= 1'b0;
         r_ev_bit     <= 1'b0;
      end else begin
         r_cs_sync    <= {r_cs_sync[0], cs_n};
         r_sclk_sync  <= {r_sclk_sync[0], sclk};
         r_din_sync   <= {r_din_sync[0], data_in};
         r_cs_prev    <= r_cs_sync[1];
         r_sclk_prev  <= r_sclk_sync[1];
         if (!w_stable)
            r_stab_cnt <= r_stab_cnt + 2'd1;
         r_ev_cs_fall <= w_stable & w_cs_fall;
         r_ev_cs_rise <= w_stable & w_cs_rise;
         r_ev_sample  <= w_stable & w_sclk_edge;
         r_ev_bit     <= r_din_sync[1];
      end
   end

`ifdef SPI_SAMPLER_TIMEOUT_EN
   localparam int C_TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [C_TO_W-1:0] r_to_cnt;

   assign w_timeout = (r_to_cnt == C_TO_W'(TIMEOUT_CYCLES - 1)) && !r_ev_sample;
`else
   assign w_timeout = 1'b0;
`endif

   assign w_frame_end = r_ev_cs_rise || !en || w_timeout;

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         r_state      <= ST_STARTUP;
         r_shift      <= '0;
         data_out     <= '0;
         data_valid   <= 1'b0;
         frame_active <= 1'b0;
         frame_err    <= 1'b0;
         bit_cnt      <= '0;
`ifdef SPI_SAMPLER_TIMEOUT_EN
         r_to_cnt     <= '0;
`endif
      end else begin
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
         case (r_state)
            ST_STARTUP: begin
               bit_cnt      <= '0;
               frame_active <= 1'b0;
               if (w_stable)
                  r_state <= ST_IDLE;
            end
            ST_IDLE: begin
               bit_cnt <= '0;
`ifdef SPI_SAMPLER_TIMEOUT_EN
               r_to_cnt <= '0;
`endif
               if (r_ev_cs_fall && en) begin
                  r_state      <= ST_ACTIVE;
                  frame_active <= 1'b1;
               end
            end
            ST_ACTIVE: begin
               // A word that completed just before the frame end is still delivered.
               if (w_word_done) begin
                  data_out   <= r_shift;
                  data_valid <= 1'b1;
               end
`ifdef SPI_SAMPLER_TIMEOUT_EN
               if (r_ev_sample)
                  r_to_cnt <= '0;
               else
                  r_to_cnt <= r_to_cnt + C_TO_W'(1);
`endif
               if (w_frame_end) begin
                  r_state      <= ST_IDLE;
                  frame_active <= 1'b0;
                  bit_cnt      <= '0;
                  frame_err    <= w_timeout || ((bit_cnt != '0) && !w_word_done);
               end else if (r_ev_sample) begin
                  r_shift <= w_shift_next;
                  bit_cnt <= w_word_done ? C_CNT_W'(1) : bit_cnt + C_CNT_W'(1);
               end else if (w_word_done) begin
                  bit_cnt <= '0;
               end
            end
            default: begin
               r_state      <= ST_STARTUP;
               frame_active <= 1'b0;
               bit_cnt      <= '0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire
